// File: rtl/rpi_bus_pkg.sv
// Shared constants for the RPi parallel bus controller: framing bytes, commands
// and the FSM state encoding.
package rpi_bus_pkg;

  localparam int         BUS_W      = 8;
  localparam logic [7:0] SYNC1_BYTE = 8'hB8;
  localparam logic [7:0] SYNC2_BYTE = 8'h8B;
  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;

  localparam logic [2:0] ST_SYNC1   = 3'd0;
  localparam logic [2:0] ST_SYNC2   = 3'd1;
  localparam logic [2:0] ST_CMD     = 3'd2;
  localparam logic [2:0] ST_LEN     = 3'd3;
  localparam logic [2:0] ST_RX_DATA = 3'd4;
  localparam logic [2:0] ST_TX_TURN = 3'd5;
  localparam logic [2:0] ST_TX_DATA = 3'd6;

  typedef enum logic [2:0] {
    SYNC1   = ST_SYNC1,
    SYNC2   = ST_SYNC2,
    CMD     = ST_CMD,
    LEN     = ST_LEN,
    RX_DATA = ST_RX_DATA,
    TX_TURN = ST_TX_TURN,
    TX_DATA = ST_TX_DATA
  } state_t;

endpackage

// File: rtl/rpi_bus_sync.sv
// Synchronizes bus_clk, bus_rnw and bus_data_in through equal-depth flop chains
// and produces registered rise/fall strobes aligned with the sampled byte.
module rpi_bus_sync
  import rpi_bus_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_bus_clk,
  input  logic             i_bus_rnw,
  input  logic [BUS_W-1:0] i_bus_data,
  output logic             o_rise,
  output logic             o_fall,
  output logic             o_rnw,
  output logic [BUS_W-1:0] o_data
);

  // Bundle layout: {bus_clk, bus_rnw, bus_data} so all three share one chain.
  logic [BUS_W+1:0] r_sync [SYNC_STAGES];
  logic             r_clk_d;
  logic [BUS_W+1:0] w_last;

  assign w_last = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_clk_d <= 1'b0;
      o_rise  <= 1'b0;
      o_fall  <= 1'b0;
      o_rnw   <= 1'b0;
      o_data  <= '0;
    end else begin
      r_sync[0] <= {i_bus_clk, i_bus_rnw, i_bus_data};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_clk_d <= w_last[BUS_W+1];
      o_rise  <= ~r_clk_d &  w_last[BUS_W+1];
      o_fall  <=  r_clk_d & ~w_last[BUS_W+1];
      o_rnw   <= w_last[BUS_W];
      o_data  <= w_last[BUS_W-1:0];
    end
  end

endmodule

// File: rtl/rpi_bus_ctrl.sv
// Command-level controller for the 8-bit RPi parallel bus: frame detection,
// write payload streaming to a sink, read payload streaming from a source.
module rpi_bus_ctrl
  import rpi_bus_pkg::*;
#(
  parameter int         SYNC_STAGES    = 2,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] UNDERRUN_BYTE  = 8'hEE
) (
  input  logic       clk_100mhz,
  input  logic       reset,
  input  logic       bus_clk,
  input  logic [7:0] bus_data_in,
  input  logic       bus_rnw,
  output logic [7:0] bus_data_out,
  output logic       bus_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_last,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       cmd_err,
  output logic       timeout,
  output logic       tx_underrun
);

  localparam int            TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic       w_rise, w_fall, w_rnw, w_edge, w_counting, w_to_hit;
  logic [7:0] w_byte;
  state_t     r_state;
  logic       r_rd;
  logic [8:0] r_len;
  logic [8:0] r_cnt;
  logic [TO_W-1:0] r_to_cnt;

  rpi_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk_100mhz),
    .rst        (reset),
    .i_bus_clk  (bus_clk),
    .i_bus_rnw  (bus_rnw),
    .i_bus_data (bus_data_in),
    .o_rise     (w_rise),
    .o_fall     (w_fall),
    .o_rnw      (w_rnw),
    .o_data     (w_byte)
  );

  assign busy       = (r_state != SYNC1);
  assign bus_oe     = (r_state == TX_DATA) && w_rnw;
  assign w_edge     = w_rise | w_fall;
  assign w_counting = (r_state != SYNC1) && (r_state != TX_TURN);
  // An edge in the same cycle as the terminal count cancels the timeout.
  assign w_to_hit   = w_counting && !w_edge && (r_to_cnt == TO_LAST);

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset)                      r_to_cnt <= '0;
    else if (w_edge || !w_counting) r_to_cnt <= '0;
    else if (r_to_cnt != TO_LAST)   r_to_cnt <= r_to_cnt + 1'b1;
  end

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      r_state      <= SYNC1;
      r_rd         <= 1'b0;
      r_len        <= '0;
      r_cnt        <= '0;
      bus_data_out <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_last      <= 1'b0;
      tx_ready     <= 1'b0;
      cmd_err      <= 1'b0;
      timeout      <= 1'b0;
      tx_underrun  <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      rx_last     <= 1'b0;
      tx_ready    <= 1'b0;
      cmd_err     <= 1'b0;
      timeout     <= 1'b0;
      tx_underrun <= 1'b0;
      if (w_to_hit) begin
        timeout <= 1'b1;
        r_state <= SYNC1;
      end else begin
        case (r_state)
          SYNC1: if (w_rise && w_byte == SYNC1_BYTE) r_state <= SYNC2;
          SYNC2: if (w_rise) begin
            if (w_byte == SYNC2_BYTE)      r_state <= CMD;
            else if (w_byte == SYNC1_BYTE) r_state <= SYNC2;
            else                           r_state <= SYNC1;
          end
          CMD: if (w_rise) begin
            if (w_byte == CMD_WRITE) begin
              r_rd    <= 1'b0;
              r_state <= LEN;
            end else if (w_byte == CMD_READ) begin
              r_rd    <= 1'b1;
              r_state <= LEN;
            end else begin
              cmd_err <= 1'b1;
              r_state <= SYNC1;
            end
          end
          LEN: if (w_rise) begin
            r_len   <= {1'b0, w_byte} + 9'd1;
            r_cnt   <= '0;
            r_state <= r_rd ? TX_TURN : RX_DATA;
          end
          RX_DATA: if (w_rise) begin
            rx_data  <= w_byte;
            rx_valid <= 1'b1;
            if (r_cnt == r_len - 9'd1) begin
              rx_last <= 1'b1;
              r_state <= SYNC1;
            end else begin
              r_cnt <= r_cnt + 9'd1;
            end
          end
          TX_TURN: if (w_rnw) r_state <= TX_DATA;
          TX_DATA: begin
            // The host dropping rnw mid-payload ends the read early.
            if (!w_rnw) begin
              r_state <= SYNC1;
            end else if (w_fall) begin
              tx_ready <= 1'b1;
              if (tx_valid) begin
                bus_data_out <= tx_data;
              end else begin
                bus_data_out <= UNDERRUN_BYTE;
                tx_underrun  <= 1'b1;
              end
            end else if (w_rise) begin
              if (r_cnt == r_len - 9'd1) r_state <= SYNC1;
              else                       r_cnt   <= r_cnt + 9'd1;
            end
          end
          default: r_state <= SYNC1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rpi_bus_ctrl.sv
// Directed bench for rpi_bus_ctrl: table of write/command frames plus
// hand-written read, underrun, timeout and reset sequences.
module tb_rpi_bus_ctrl;

  localparam int HP = 8;
  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       bus_clk;
  logic [7:0] bus_data_in;
  logic       bus_rnw;
  logic [7:0] bus_data_out;
  logic       bus_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_last;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       cmd_err;
  logic       timeout;
  logic       tx_underrun;

  rpi_bus_ctrl #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TO), .UNDERRUN_BYTE(8'hEE)) dut (
    .clk_100mhz   (clk),
    .reset        (reset),
    .bus_clk      (bus_clk),
    .bus_data_in  (bus_data_in),
    .bus_rnw      (bus_rnw),
    .bus_data_out (bus_data_out),
    .bus_oe       (bus_oe),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_last      (rx_last),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .cmd_err      (cmd_err),
    .timeout      (timeout),
    .tx_underrun  (tx_underrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] rx_mem [1024];
  logic       rxl_mem [1024];
  int rx_n = 0, n_txr = 0, n_err = 0, n_to = 0, n_und = 0;

  always @(negedge clk) begin
    if (rx_valid && rx_n < 1024) begin
      rx_mem[rx_n]  = rx_data;
      rxl_mem[rx_n] = rx_last;
      rx_n++;
    end
    if (tx_ready)    n_txr++;
    if (cmd_err)     n_err++;
    if (timeout)     n_to++;
    if (tx_underrun) n_und++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    bus_data_in = b;
    wait_clk(HP);
    bus_clk = 1'b0;
    wait_clk(HP);
    bus_clk = 1'b1;
    wait_clk(HP);
  endtask

  task automatic read_slot(input logic [7:0] d, input logic v, input logic [7:0] exp_pad);
    tx_data  = d;
    tx_valid = v;
    wait_clk(HP);
    bus_clk = 1'b0;
    wait_clk(HP);
    chk("pad_byte", {24'd0, bus_data_out}, {24'd0, exp_pad});
    chk("pad_oe", {31'd0, bus_oe}, 32'd1);
    bus_clk = 1'b1;
    wait_clk(HP);
    tx_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  len;
    logic [31:0] d;
    int          nsend;
    int          exp_rx;
    int          exp_err;
  } wvec_t;

  wvec_t wv [5];

  initial begin
    int b_rx, b_err, b_txr, b_und, b_to;
    logic [31:0] dv;

    wv[0] = '{8'h01, 8'h03, 32'hA3A2A1A0, 4, 4, 0};
    wv[1] = '{8'h07, 8'h00, 32'h00000000, 0, 0, 1};
    wv[2] = '{8'h01, 8'h00, 32'h0000005A, 1, 1, 0};
    wv[3] = '{8'h01, 8'h01, 32'h00002211, 2, 2, 0};
    wv[4] = '{8'h00, 8'h00, 32'h00000000, 0, 0, 1};

    reset = 1'b1; bus_clk = 1'b1; bus_data_in = 8'h00; bus_rnw = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0;
    wait_clk(4);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_oe", {31'd0, bus_oe}, 32'd0);
    chk("rst_pad", {24'd0, bus_data_out}, 32'd0);
    chk("rst_outs", {26'd0, rx_valid, rx_last, tx_ready, cmd_err, timeout, tx_underrun}, 32'd0);
    reset = 1'b0;
    wait_clk(10);

    // Write / command table
    for (int v = 0; v < 5; v++) begin
      b_rx = rx_n; b_err = n_err; dv = wv[v].d;
      send(8'hB8); send(8'h8B); send(wv[v].cmd);
      if (wv[v].exp_err == 0) begin
        send(wv[v].len);
        for (int i = 0; i < wv[v].nsend; i++) send(dv[8*i +: 8]);
      end
      wait_clk(8);
      chk($sformatf("v%0d_rx_count", v), rx_n - b_rx, wv[v].exp_rx);
      for (int i = 0; i < wv[v].exp_rx; i++) begin
        chk($sformatf("v%0d_rx_data%0d", v, i), {24'd0, rx_mem[b_rx+i]}, {24'd0, dv[8*i +: 8]});
        chk($sformatf("v%0d_rx_last%0d", v, i), {31'd0, rxl_mem[b_rx+i]},
            (i == wv[v].exp_rx - 1) ? 32'd1 : 32'd0);
      end
      chk($sformatf("v%0d_cmd_err", v), n_err - b_err, wv[v].exp_err);
      chk($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd0);
    end

    // 256-byte read, source always valid counting 00..FF
    b_txr = n_txr; b_und = n_und;
    send(8'hB8); send(8'h8B); send(8'h02); send(8'hFF);
    chk("rd256_oe_turn", {31'd0, bus_oe}, 32'd0);
    bus_rnw = 1'b1;
    wait_clk(HP);
    chk("rd256_oe_on", {31'd0, bus_oe}, 32'd1);
    for (int i = 0; i < 256; i++) read_slot(8'(i), 1'b1, 8'(i));
    chk("rd256_oe_end", {31'd0, bus_oe}, 32'd0);
    chk("rd256_busy_end", {31'd0, busy}, 32'd0);
    chk("rd256_tx_ready", n_txr - b_txr, 256);
    chk("rd256_underrun", n_und - b_und, 0);
    bus_rnw = 1'b0;
    wait_clk(HP);

    // Read len=01, first slot underruns
    b_txr = n_txr; b_und = n_und;
    send(8'hB8); send(8'h8B); send(8'h02); send(8'h01);
    bus_rnw = 1'b1;
    wait_clk(HP);
    read_slot(8'h55, 1'b0, 8'hEE);
    read_slot(8'hC3, 1'b1, 8'hC3);
    chk("und_count", n_und - b_und, 1);
    chk("und_tx_ready", n_txr - b_txr, 2);
    chk("und_oe_end", {31'd0, bus_oe}, 32'd0);
    bus_rnw = 1'b0;
    wait_clk(HP);

    // Timeout mid-payload, then a fresh frame
    b_rx = rx_n; b_to = n_to;
    send(8'hB8); send(8'h8B); send(8'h01); send(8'h04); send(8'h11); send(8'h22);
    chk("to_busy_before", {31'd0, busy}, 32'd1);
    wait_clk(2 * TO);
    chk("to_pulse", n_to - b_to, 1);
    chk("to_busy_after", {31'd0, busy}, 32'd0);
    chk("to_rx_count", rx_n - b_rx, 2);
    chk("to_no_last", {31'd0, rxl_mem[b_rx+1]}, 32'd0);
    b_rx = rx_n;
    send(8'hB8); send(8'h8B); send(8'h01); send(8'h00); send(8'h77);
    wait_clk(8);
    chk("to_recover_count", rx_n - b_rx, 1);
    chk("to_recover_data", {24'd0, rx_mem[b_rx]}, 32'h77);
    chk("to_recover_last", {31'd0, rxl_mem[b_rx]}, 32'd1);

    // Reset mid-TX_DATA
    send(8'hB8); send(8'h8B); send(8'h02); send(8'h03);
    bus_rnw = 1'b1;
    wait_clk(HP);
    tx_data = 8'h9C; tx_valid = 1'b1;
    bus_clk = 1'b0;
    wait_clk(HP);
    chk("rst_mid_oe_before", {31'd0, bus_oe}, 32'd1);
    chk("rst_mid_pad_before", {24'd0, bus_data_out}, 32'h9C);
    reset = 1'b1;
    #1;
    chk("rst_mid_oe", {31'd0, bus_oe}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_pad", {24'd0, bus_data_out}, 32'd0);
    chk("rst_mid_outs", {26'd0, rx_valid, rx_last, tx_ready, cmd_err, timeout, tx_underrun}, 32'd0);
    tx_valid = 1'b0; bus_rnw = 1'b0; bus_clk = 1'b1; bus_data_in = 8'h00;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(10);
    b_rx = rx_n;
    send(8'hB8); send(8'hB8); send(8'h8B); send(8'h01); send(8'h00); send(8'h5A);
    wait_clk(8);
    chk("rst_after_count", rx_n - b_rx, 1);
    chk("rst_after_data", {24'd0, rx_mem[b_rx]}, 32'h5A);
    chk("rst_after_last", {31'd0, rxl_mem[b_rx]}, 32'd1);

    chk("total_timeouts", n_to, 1);
    chk("total_underruns", n_und, 1);
    chk("total_cmd_errs", n_err, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
